moore_seq_ctrl: RTL and testbench

- Run controller for the on-chip Moore machine (serial input x1, registered output z1).
- Accepts a serial test pattern through a valid/ready handshake, clears the machine, and shifts the pattern LSB-first onto x1, one bit per enabled cycle.
- Counts z1 hits over the run and reports the count with a one-cycle done pulse.
- Sits between the tt_um_ top-level pin logic and the Moore machine instance.

---
 rtl/moore_seq_pkg.sv | 22 ++
 rtl/moore_seq_shifter.sv | 45 ++++
 rtl/moore_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_moore_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moore_seq_pkg.sv
// Shared definitions for the Moore machine run controller: FSM state
// encodings, default parameter values and the pattern-length width helper.
package moore_seq_pkg;

    localparam int PAT_W_DEF     = 8;
    localparam int CNT_W_DEF     = 4;
    localparam int DRAIN_CYC_DEF = 1;

    // FSM state encodings
    localparam int         ST_W     = 3;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Bits needed to express a length from 0 to pat_w inclusive.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/moore_seq_shifter.sv
// Parallel-in serial-out pattern register with a remaining-bit down-counter.
// Loaded once per run, shifted right once per RUN cycle; bit_o is the next
// bit to drive onto x1.
module moore_seq_shifter
    import moore_seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = len_w(PAT_W_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [PAT_W-1:0] load_data_i,
    input  logic [LEN_W-1:0] load_len_i,
    input  logic             shift_i,
    output logic             bit_o,
    output logic             empty_o,
    output logic             last_o
);

    logic [PAT_W-1:0] shreg_q;
    logic [LEN_W-1:0] cnt_q;

    // Load on run accept, otherwise shift out LSB-first while bits remain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (en_i) begin
            if (load_i) begin
                shreg_q <= load_data_i;
                cnt_q   <= load_len_i;
            end else if (shift_i && (cnt_q != '0)) begin
                shreg_q <= shreg_q >> 1;
                cnt_q   <= cnt_q - 1'b1;
            end
        end
    end

    assign bit_o   = shreg_q[0];
    assign empty_o = (cnt_q == '0);
    assign last_o  = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/moore_seq_ctrl.sv
// Run controller for the Moore machine: accepts a pattern, clears the
// machine, shifts the pattern onto x1 LSB-first and counts z1 hits.
// Build option: define MOORE_SEQ_EDGE_EN to count only 0->1 transitions of
// the sampled z1 instead of every sampled high level.
module moore_seq_ctrl
    import moore_seq_pkg::*;
#(
    parameter int  PAT_W     = PAT_W_DEF,
    parameter int  CNT_W     = CNT_W_DEF,
    parameter int  DRAIN_CYC = DRAIN_CYC_DEF,   // must be at least 1
    localparam int LEN_W     = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [PAT_W-1:0] pat_data,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             abort,
    output logic             x1,
    output logic             m_rst_n,
    input  logic             z1_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             cnt_sat
);

    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    logic [ST_W-1:0]  state_q, state_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic             sample_en_q, sample_en_d;
    logic [CNT_W-1:0] hit_cnt_q;
    logic             cnt_sat_q;

    logic             accept;
    logic [LEN_W-1:0] len_clamped;
    logic             sh_bit, sh_empty, sh_last;
    logic             sample_active;
    logic             hit_event;

    assign start_ready = ena && (state_q == ST_IDLE);
    assign accept      = start_valid && start_ready;
    assign len_clamped = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;

    moore_seq_shifter #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (ena),
        .load_i      (accept),
        .load_data_i (pat_data),
        .load_len_i  (len_clamped),
        .shift_i     (state_q == ST_RUN),
        .bit_o       (sh_bit),
        .empty_o     (sh_empty),
        .last_o      (sh_last)
    );

    // Next-state logic; abort overrides everything except IDLE
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE:  if (start_valid) state_d = ST_CLR;
            ST_CLR:   state_d = sh_empty ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (sh_last) begin
                    state_d = ST_DRAIN;
                    drain_d = DRN_W'(DRAIN_CYC - 1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_DONE;
                else               drain_d = drain_q - 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    // z1 lags x1 by one cycle, so sampling trails RUN by one cycle; an abort
    // cancels the trailing sample so nothing is counted after returning to IDLE
    assign sample_en_d   = (state_q == ST_RUN) && !abort;
    assign sample_active = sample_en_q || (state_q == ST_DRAIN);

    // FSM, drain counter and sample-enable registers, frozen while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drain_q     <= '0;
            sample_en_q <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            sample_en_q <= sample_en_d;
        end
    end

`ifdef MOORE_SEQ_EDGE_EN
    logic z1_prev_q;

    // Previous sampled z1, cleared at accept so a first-sample high counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z1_prev_q <= 1'b0;
        end else if (ena) begin
            if (accept)             z1_prev_q <= 1'b0;
            else if (sample_active) z1_prev_q <= z1_in;
        end
    end

    assign hit_event = sample_active && z1_in && !z1_prev_q;
`else
    assign hit_event = sample_active && z1_in;
`endif

    // Saturating hit counter with sticky overflow flag, cleared at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
            cnt_sat_q <= 1'b0;
        end else if (ena) begin
            if (accept) begin
                hit_cnt_q <= '0;
                cnt_sat_q <= 1'b0;
            end else if (hit_event) begin
                if (hit_cnt_q == '1) cnt_sat_q <= 1'b1;
                else                 hit_cnt_q <= hit_cnt_q + 1'b1;
            end
        end
    end

    assign x1      = (state_q == ST_RUN) && sh_bit;
    assign m_rst_n = (state_q != ST_CLR);
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign hit_cnt = hit_cnt_q;
    assign cnt_sat = cnt_sat_q;

endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Directed bench for moore_seq_ctrl. Two instances share the stimulus: one
// with the default 4-bit counter and one with a 2-bit counter for saturation.
// Each has a Moore-machine stand-in: z1 = x1 delayed one cycle, cleared by
// m_rst_n and advanced only while the shared global enable is high.
module tb_moore_seq_ctrl;

`ifdef MOORE_SEQ_EDGE_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif

    // Hand-derived hit counts (level mode / edge mode)
    localparam int EXP_B6     = EDGE_MODE ? 3 : 5;
    localparam int EXP_FF     = EDGE_MODE ? 1 : 8;
    localparam int EXP_ABORT  = EDGE_MODE ? 1 : 3;
    localparam int EXP_B6_W2  = 3;
    localparam int EXP_B6_SAT = EDGE_MODE ? 0 : 1;
    localparam int EXP_FF_W2  = EDGE_MODE ? 1 : 3;
    localparam int EXP_FF_SAT = EDGE_MODE ? 0 : 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ena, start_valid, abort;
    logic [7:0] pat_data;
    logic [3:0] pat_len;

    logic       start_ready_a, x1_a, m_rst_n_a, z1_a, busy_a, done_a, cnt_sat_a;
    logic [3:0] hit_cnt_a;
    logic       start_ready_b, x1_b, m_rst_n_b, z1_b, busy_b, done_b, cnt_sat_b;
    logic [1:0] hit_cnt_b;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic seen_clr_mrst;

    moore_seq_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .start_valid(start_valid), .start_ready(start_ready_a),
        .pat_data(pat_data), .pat_len(pat_len), .abort(abort),
        .x1(x1_a), .m_rst_n(m_rst_n_a), .z1_in(z1_a),
        .busy(busy_a), .done(done_a), .hit_cnt(hit_cnt_a), .cnt_sat(cnt_sat_a)
    );

    moore_seq_ctrl #(.CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .start_valid(start_valid), .start_ready(start_ready_b),
        .pat_data(pat_data), .pat_len(pat_len), .abort(abort),
        .x1(x1_b), .m_rst_n(m_rst_n_b), .z1_in(z1_b),
        .busy(busy_b), .done(done_b), .hit_cnt(hit_cnt_b), .cnt_sat(cnt_sat_b)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)  z1_a <= 1'b0;
        else if (ena) z1_a <= m_rst_n_a ? x1_a : 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)  z1_b <= 1'b0;
        else if (ena) z1_b <= m_rst_n_b ? x1_b : 1'b0;
    end

    // Issue one run from IDLE and follow it to the done pulse. Cycle 1 is the
    // CLR cycle after the accepting edge; stalled cycles are not counted.
    task automatic run_pattern(input logic [7:0] pat, input logic [3:0] len,
                               input int stall_at, output int done_cyc,
                               output logic [7:0] bits, output int ones,
                               output int frozen_bad);
        logic hold_x1, hold_done;
        done_cyc = -1; bits = '0; ones = 0; frozen_bad = 0;
        seen_clr_mrst = 1'b1;
        start_valid = 1'b1; pat_data = pat; pat_len = len;
        @(negedge clk);
        start_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) seen_clr_mrst = m_rst_n_a;
            if (c >= 2 && c <= 9) bits[3'(c - 2)] = x1_a;
            ones += (x1_a === 1'b1) ? 1 : 0;
            if (c == stall_at) begin
                hold_x1 = x1_a; hold_done = done_a; ena = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (x1_a !== hold_x1 || done_a !== hold_done ||
                        busy_a !== 1'b1 || start_ready_a !== 1'b0) frozen_bad++;
                end
                ena = 1'b1;
            end
            if (done_a === 1'b1) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        $display("run pat=%h len=%0d stall_at=%0d done_cycle=%0d x1_bits=%h hit_a=%0d sat_a=%0b hit_b=%0d sat_b=%0b",
                 pat, len, stall_at, done_cyc, bits, hit_cnt_a, cnt_sat_a, hit_cnt_b, cnt_sat_b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; start_valid = 1'b0; abort = 1'b0;
        pat_data = '0; pat_len = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy_a, done_a, x1_a, m_rst_n_a, cnt_sat_a} !== 5'b00010) begin
            n_bad++;
            $display("FAIL reset_flags: busy/done/x1/m_rst_n/cnt_sat got %b want 00010",
                     {busy_a, done_a, x1_a, m_rst_n_a, cnt_sat_a});
        end
        n_cmp++;
        if (hit_cnt_a !== 4'd0) begin
            n_bad++; $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt_a);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (start_ready_a !== 1'b1) begin
            n_bad++; $display("FAIL reset_start_ready: got %b want 1", start_ready_a);
        end
    endtask

    task automatic test_level();
        int dc, ones, fb; logic [7:0] bits;
        run_pattern(8'hB6, 4'd8, 0, dc, bits, ones, fb);
        n_cmp++;
        if (dc !== 11) begin n_bad++; $display("FAIL b6_done_cycle: got %0d want 11", dc); end
        n_cmp++;
        if (bits !== 8'hB6) begin n_bad++; $display("FAIL b6_x1_seq: got %h want b6", bits); end
        n_cmp++;
        if (seen_clr_mrst !== 1'b0) begin n_bad++; $display("FAIL b6_clr_mrst: got %b want 0", seen_clr_mrst); end
        @(negedge clk);
        n_cmp++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL b6_done_width: done=%b busy=%b want 0 0", done_a, busy_a);
        end
        n_cmp++;
        if (int'(hit_cnt_a) !== EXP_B6 || cnt_sat_a !== 1'b0) begin
            n_bad++; $display("FAIL b6_hits: got %0d/%b want %0d/0", hit_cnt_a, cnt_sat_a, EXP_B6);
        end
        n_cmp++;
        if (int'(hit_cnt_b) !== EXP_B6_W2 || int'(cnt_sat_b) !== EXP_B6_SAT) begin
            n_bad++; $display("FAIL b6_hits_w2: got %0d/%b want %0d/%0d", hit_cnt_b, cnt_sat_b, EXP_B6_W2, EXP_B6_SAT);
        end
    endtask

    task automatic test_saturate();
        int dc, ones, fb; logic [7:0] bits;
        run_pattern(8'hFF, 4'd8, 0, dc, bits, ones, fb);
        @(negedge clk);
        n_cmp++;
        if (int'(hit_cnt_b) !== EXP_FF_W2 || int'(cnt_sat_b) !== EXP_FF_SAT) begin
            n_bad++; $display("FAIL ff_sat_w2: got %0d/%b want %0d/%0d", hit_cnt_b, cnt_sat_b, EXP_FF_W2, EXP_FF_SAT);
        end
        n_cmp++;
        if (int'(hit_cnt_a) !== EXP_FF || cnt_sat_a !== 1'b0) begin
            n_bad++; $display("FAIL ff_hits: got %0d/%b want %0d/0", hit_cnt_a, cnt_sat_a, EXP_FF);
        end
    endtask

    task automatic test_zero_len();
        int dc, ones, fb; logic [7:0] bits;
        run_pattern(8'hFF, 4'd0, 0, dc, bits, ones, fb);
        n_cmp++;
        if (dc !== 2) begin n_bad++; $display("FAIL zero_len_done_cycle: got %0d want 2", dc); end
        n_cmp++;
        if (ones !== 0 || hit_cnt_a !== 4'd0) begin
            n_bad++; $display("FAIL zero_len_x1_hits: x1 ones %0d hit %0d want 0 0", ones, hit_cnt_a);
        end
        @(negedge clk);
    endtask

    task automatic test_clamp();
        int dc, ones, fb; logic [7:0] bits;
        run_pattern(8'hFF, 4'd12, 0, dc, bits, ones, fb);
        n_cmp++;
        if (dc !== 11) begin n_bad++; $display("FAIL clamp_done_cycle: got %0d want 11", dc); end
        n_cmp++;
        if (ones !== 8) begin n_bad++; $display("FAIL clamp_run_bits: got %0d want 8", ones); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic seen_done;
        start_valid = 1'b1; pat_data = 8'hFF; pat_len = 4'd8;
        @(negedge clk);                 // cycle 1: CLR
        start_valid = 1'b0;
        repeat (4) @(negedge clk);      // cycle 5: RUN cycle 4
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({busy_a, start_ready_a, x1_a, m_rst_n_a, done_a} !== 5'b01010) begin
            n_bad++; $display("FAIL abort_state: busy/ready/x1/m_rst_n/done got %b want 01010",
                              {busy_a, start_ready_a, x1_a, m_rst_n_a, done_a});
        end
        seen_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done_a === 1'b1) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got done pulse want none"); end
        n_cmp++;
        if (int'(hit_cnt_a) !== EXP_ABORT) begin
            n_bad++; $display("FAIL abort_hits: got %0d want %0d", hit_cnt_a, EXP_ABORT);
        end
        $display("abort run pat=ff hit_a=%0d", hit_cnt_a);
    endtask

    task automatic test_abort_start_idle();
        int wait_cyc;
        start_valid = 1'b1; abort = 1'b1; pat_data = 8'h03; pat_len = 4'd2;
        @(negedge clk);
        start_valid = 1'b0; abort = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b1 || m_rst_n_a !== 1'b0) begin
            n_bad++; $display("FAIL start_with_abort: busy=%b m_rst_n=%b want 1 0", busy_a, m_rst_n_a);
        end
        wait_cyc = 0;
        while (done_a !== 1'b1 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_cmp++;
        if (wait_cyc !== 4) begin n_bad++; $display("FAIL start_with_abort_done: got %0d want 4", wait_cyc); end
        $display("start+abort run pat=03 len=2 done_after=%0d", wait_cyc);
        @(negedge clk);
    endtask

    task automatic test_stall();
        int dc, ones, fb; logic [7:0] bits;
        run_pattern(8'hB6, 4'd8, 5, dc, bits, ones, fb);
        n_cmp++;
        if (fb !== 0) begin n_bad++; $display("FAIL stall_run_frozen: got %0d bad cycles want 0", fb); end
        n_cmp++;
        if (dc !== 11 || bits !== 8'hB6) begin
            n_bad++; $display("FAIL stall_run_seq: cycle %0d bits %h want 11 b6", dc, bits);
        end
        @(negedge clk);
        n_cmp++;
        if (int'(hit_cnt_a) !== EXP_B6) begin
            n_bad++; $display("FAIL stall_run_hits: got %0d want %0d", hit_cnt_a, EXP_B6);
        end
        run_pattern(8'hB6, 4'd8, 11, dc, bits, ones, fb);
        n_cmp++;
        if (fb !== 0 || dc !== 11) begin
            n_bad++; $display("FAIL stall_done_held: bad %0d cycle %0d want 0 11", fb, dc);
        end
        @(negedge clk);
        n_cmp++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL stall_done_release: done=%b busy=%b want 0 0", done_a, busy_a);
        end
    endtask

    task automatic test_async_reset();
        logic seen_done;
        start_valid = 1'b1; pat_data = 8'hB6; pat_len = 4'd8;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (4) @(negedge clk);      // cycle 5: one hit counted so far
        n_cmp++;
        if (hit_cnt_a !== 4'd1 || busy_a !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_hits: hit %0d busy %b want 1 1", hit_cnt_a, busy_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy_a, done_a, x1_a, m_rst_n_a, cnt_sat_a} !== 5'b00010 || hit_cnt_a !== 4'd0) begin
            n_bad++; $display("FAIL async_reset: flags %b hit %0d want 00010 0",
                              {busy_a, done_a, x1_a, m_rst_n_a, cnt_sat_a}, hit_cnt_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin n_bad++; $display("FAIL async_reset_no_done: activity after reset"); end
        $display("async reset mid-run hit_a=%0d busy_a=%b", hit_cnt_a, busy_a);
    endtask

    initial begin
        test_reset();
        test_level();
        test_saturate();
        test_zero_len();
        test_clamp();
        test_abort();
        test_abort_start_idle();
        test_stall();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
